// File: rtl/beam_sum_tree_pkg.sv
// Shared constants and elaboration-time helpers for the beamformer sum tree.
package beam_sum_tree_pkg;

    localparam int NUM_CH_PER_LANE = 24;
    localparam int MULT_OUT_WIDTH  = 32;
    localparam int ACC_WIDTH       = 48;
    localparam int INT_CNT_WIDTH   = 10;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Element count after lvl halvings; odd leftovers round up.
    function automatic int level_width(input int n, input int lvl);
        int w;
        w = n;
        for (int i = 0; i < lvl; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/beam_sum_tree_cplx_add_level.sv
// One registered level of the complex adder tree: N inputs to ceil(N/2) outputs.
module cplx_add_level #(
    parameter int N = 2,
    parameter int W = 8,
    parameter int M = (N + 1) / 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sync_clr,
    input  logic           in_vld,
    input  logic [N*W-1:0] in_re,
    input  logic [N*W-1:0] in_im,
    output logic           out_vld,
    output logic [M*W-1:0] out_re,
    output logic [M*W-1:0] out_im
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_re  <= '0;
            out_im  <= '0;
        end else begin
            out_vld <= in_vld & ~sync_clr;
            for (int j = 0; j < N / 2; j++) begin
                out_re[j*W +: W] <= in_re[2*j*W +: W] + in_re[(2*j+1)*W +: W];
                out_im[j*W +: W] <= in_im[2*j*W +: W] + in_im[(2*j+1)*W +: W];
            end
            // Unpaired element is delayed one level so every path has equal latency.
            if ((N % 2) == 1) begin
                out_re[(M-1)*W +: W] <= in_re[(N-1)*W +: W];
                out_im[(M-1)*W +: W] <= in_im[(N-1)*W +: W];
            end
        end
    end

endmodule

// File: rtl/beam_sum_tree.sv
// Complex adder tree plus coherent integrator for one beamformer lane.
// Define SATURATE_EN to clamp the result to OUT_WIDTH (otherwise it wraps).
module beam_sum_tree
    import beam_sum_tree_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_PER_LANE,
    parameter int IN_WIDTH  = MULT_OUT_WIDTH,
    parameter int OUT_WIDTH = ACC_WIDTH,
    parameter int CNT_WIDTH = INT_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*2*IN_WIDTH-1:0] data_in_packed,
    input  logic                        in_valid,
    input  logic [CNT_WIDTH-1:0]        int_len,
    input  logic                        sync_clr,
    output logic signed [OUT_WIDTH-1:0] sum_real,
    output logic signed [OUT_WIDTH-1:0] sum_imag,
    output logic                        sum_valid,
    output logic                        sum_ovf
);

    localparam int LEVELS = clog2(NUM_CH);
    localparam int TW     = IN_WIDTH + LEVELS;
    localparam int IW     = TW + CNT_WIDTH;
    localparam int EW     = (IW > OUT_WIDTH) ? IW : OUT_WIDTH;

    logic [NUM_CH*TW-1:0] ext_re, ext_im;

    always_comb begin
        ext_re = '0;
        ext_im = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ext_re[k*TW +: TW] = TW'($signed(data_in_packed[k*2*IN_WIDTH +: IN_WIDTH]));
            ext_im[k*TW +: TW] = TW'($signed(data_in_packed[k*2*IN_WIDTH+IN_WIDTH +: IN_WIDTH]));
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = level_width(NUM_CH, l);
        localparam int N_OUT = level_width(NUM_CH, l + 1);
        logic [N_IN*TW-1:0]  in_re, in_im;
        logic                in_vld;
        logic [N_OUT*TW-1:0] out_re, out_im;
        logic                out_vld;

        if (l == 0) begin : g_first
            assign in_re  = ext_re;
            assign in_im  = ext_im;
            assign in_vld = in_valid;
        end else begin : g_next
            assign in_re  = g_lvl[l-1].out_re;
            assign in_im  = g_lvl[l-1].out_im;
            assign in_vld = g_lvl[l-1].out_vld;
        end

        cplx_add_level #(.N(N_IN), .W(TW), .M(N_OUT)) u_level (
            .clk      (clk),
            .rst      (rst),
            .sync_clr (sync_clr),
            .in_vld   (in_vld),
            .in_re    (in_re),
            .in_im    (in_im),
            .out_vld  (out_vld),
            .out_re   (out_re),
            .out_im   (out_im)
        );
    end

    logic signed [TW-1:0] tree_re, tree_im;
    logic                 tree_vld;

    assign tree_re  = g_lvl[LEVELS-1].out_re;
    assign tree_im  = g_lvl[LEVELS-1].out_im;
    assign tree_vld = g_lvl[LEVELS-1].out_vld;

    logic signed [IW-1:0]    acc_real, acc_imag, nxt_re, nxt_im;
    logic [CNT_WIDTH-1:0]    cnt, len_q, len_eff, cnt_nxt;
    logic                    first, done;
    logic [OUT_WIDTH-1:0]    out_r, out_i;
    logic                    ovf;

    always_comb begin
        first   = (cnt == '0);
        len_eff = len_q;
        if (first) begin
            len_eff = (int_len == '0) ? CNT_WIDTH'(1) : int_len;
        end
        nxt_re  = first ? IW'(tree_re) : acc_real + IW'(tree_re);
        nxt_im  = first ? IW'(tree_im) : acc_imag + IW'(tree_im);
        cnt_nxt = cnt + 1'b1;
        done    = (cnt_nxt == len_eff);
    end

`ifdef SATURATE_EN
    logic signed [EW-1:0] ext_r, ext_i, sat_max, sat_min;
    logic                 hi_r, lo_r, hi_i, lo_i;

    always_comb begin
        sat_max = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        sat_min = ~sat_max;
        ext_r   = EW'(nxt_re);
        ext_i   = EW'(nxt_im);
        hi_r    = ext_r > sat_max;
        lo_r    = ext_r < sat_min;
        hi_i    = ext_i > sat_max;
        lo_i    = ext_i < sat_min;
        out_r   = hi_r ? sat_max[OUT_WIDTH-1:0] : (lo_r ? sat_min[OUT_WIDTH-1:0] : ext_r[OUT_WIDTH-1:0]);
        out_i   = hi_i ? sat_max[OUT_WIDTH-1:0] : (lo_i ? sat_min[OUT_WIDTH-1:0] : ext_i[OUT_WIDTH-1:0]);
        ovf     = hi_r | lo_r | hi_i | lo_i;
    end
`else
    always_comb begin
        out_r = OUT_WIDTH'(nxt_re);
        out_i = OUT_WIDTH'(nxt_im);
        ovf   = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_real  <= '0;
            acc_imag  <= '0;
            cnt       <= '0;
            len_q     <= '0;
            sum_real  <= '0;
            sum_imag  <= '0;
            sum_valid <= 1'b0;
            sum_ovf   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (sync_clr) begin
                cnt <= '0;
            end else if (tree_vld) begin
                if (first) begin
                    len_q <= len_eff;
                end
                // Completing sample goes straight to the output so the next frame starts without a gap.
                if (done) begin
                    cnt       <= '0;
                    sum_real  <= out_r;
                    sum_imag  <= out_i;
                    sum_ovf   <= ovf;
                    sum_valid <= 1'b1;
                end else begin
                    cnt      <= cnt_nxt;
                    acc_real <= nxt_re;
                    acc_imag <= nxt_im;
                end
            end
        end
    end

endmodule

// File: tb/tb_beam_sum_tree.sv
// Directed self-checking bench: 24-channel lane (OUT_WIDTH 40) plus a 5-channel lane.
module tb_beam_sum_tree;

    localparam int NCH = 24;
    localparam int IWD = 32;
    localparam int OW  = 40;
    localparam int CW  = 10;
    localparam int N5  = 5;
    localparam int OW5 = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH*2*IWD-1:0] din;
    logic                 vld, sclr;
    logic [CW-1:0]        ilen;
    logic signed [OW-1:0] sre, sim;
    logic                 sv, sovf;

    logic [N5*2*IWD-1:0]   din5;
    logic                  vld5, sclr5;
    logic [CW-1:0]         ilen5;
    logic signed [OW5-1:0] sre5, sim5;
    logic                  sv5, sovf5;

    beam_sum_tree #(.NUM_CH(NCH), .IN_WIDTH(IWD), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .data_in_packed(din), .in_valid(vld), .int_len(ilen),
        .sync_clr(sclr), .sum_real(sre), .sum_imag(sim), .sum_valid(sv), .sum_ovf(sovf)
    );

    beam_sum_tree #(.NUM_CH(N5), .IN_WIDTH(IWD), .OUT_WIDTH(OW5), .CNT_WIDTH(CW)) dut5 (
        .clk(clk), .rst(rst), .data_in_packed(din5), .in_valid(vld5), .int_len(ilen5),
        .sync_clr(sclr5), .sum_real(sre5), .sum_imag(sim5), .sum_valid(sv5), .sum_ovf(sovf5)
    );

    typedef struct {
        int     cyc;
        longint re;
        longint im;
        longint ovf;
    } pulse_t;

    pulse_t q[$];
    pulse_t q5[$];
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sv === 1'b1) q.push_back('{cyc, longint'(sre), longint'(sim), longint'(sovf)});
            if (sv5 === 1'b1) q5.push_back('{cyc, longint'(sre5), longint'(sim5), longint'(sovf5)});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pulse(input string tag, input bit use5, input int i, input int c,
                               input longint re, input longint im, input longint ovf);
        pulse_t p;
        if (use5) begin
            if (i >= q5.size()) return;
            p = q5[i];
        end else begin
            if (i >= q.size()) return;
            p = q[i];
        end
        check({tag, "_cyc"}, longint'(p.cyc), longint'(c));
        check({tag, "_re"}, p.re, re);
        check({tag, "_im"}, p.im, im);
        check({tag, "_ovf"}, p.ovf, ovf);
    endtask

    task automatic set_all(input int re, input int im);
        for (int k = 0; k < NCH; k++) begin
            din[k*2*IWD +: IWD]     = re;
            din[k*2*IWD+IWD +: IWD] = im;
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NCH; k++) begin
            din[k*2*IWD +: IWD]     = k;
            din[k*2*IWD+IWD +: IWD] = 0;
        end
    endtask

    int     c0;
    longint sat_exp_re;
    longint sat_exp_ovf;
    logic [63:0] exact;

    initial begin
        vld = 1'b0; sclr = 1'b0; ilen = CW'(1); din = '0;
        vld5 = 1'b0; sclr5 = 1'b0; ilen5 = CW'(1); din5 = '0;

        // Power-on reset
        step(3);
        check("rst_re", longint'(sre), 0);
        check("rst_im", longint'(sim), 0);
        check("rst_valid", longint'(sv), 0);
        check("rst_ovf", longint'(sovf), 0);
        check("rst5_re", longint'(sre5), 0);
        check("rst5_valid", longint'(sv5), 0);
        rst = 1'b0;
        step(1);

        // Pass-through, int_len = 1
        set_all(1, -2);
        ilen = CW'(1);
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(10);
        vld = 1'b0;
        step(10);
        check("pt_count", longint'(q.size()), 10);
        for (int i = 0; i < 10; i++) check_pulse("pt", 1'b0, i, c0 + 6 + i, 24, -48, 0);
        check("pt_hold_re", longint'(sre), 24);
        check("pt_hold_valid", longint'(sv), 0);

        // Mid-frame reset
        set_all(100, 0);
        ilen = CW'(4);
        q.delete();
        vld = 1'b1;
        step(2);
        vld = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
        check("mrst_re_async", longint'(sre), 0);
        check("mrst_im_async", longint'(sim), 0);
        step(3);
        check("mrst_re", longint'(sre), 0);
        check("mrst_valid", longint'(sv), 0);
        check("mrst_ovf", longint'(sovf), 0);
        rst = 1'b0;
        step(1);
        set_all(1, 0);
        c0 = cyc;
        vld = 1'b1;
        step(4);
        vld = 1'b0;
        step(12);
        check("mrst_count", longint'(q.size()), 1);
        check_pulse("mrst_frame", 1'b0, 0, c0 + 9, 96, 0, 0);

        // Integration, int_len = 4, back-to-back frames
        set_ramp();
        ilen = CW'(4);
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(8);
        vld = 1'b0;
        step(10);
        check("int_count", longint'(q.size()), 2);
        check_pulse("int_f0", 1'b0, 0, c0 + 9, 1104, 0, 0);
        check_pulse("int_f1", 1'b0, 1, c0 + 13, 1104, 0, 0);

        // int_len changed mid-frame applies to the following frame only
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(6);
        vld = 1'b0;
        step(1);
        ilen = CW'(2);
        step(12);
        check("len_count", longint'(q.size()), 2);
        check_pulse("len_f0", 1'b0, 0, c0 + 9, 1104, 0, 0);
        check_pulse("len_f1", 1'b0, 1, c0 + 11, 552, 0, 0);

        // sync_clr after 2 of 4 accepted samples, with more in flight and one dropped input
        set_all(50, 0);
        ilen = CW'(4);
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(2);
        vld = 1'b0;
        step(3);
        vld = 1'b1;
        step(2);
        sclr = 1'b1;
        step(1);
        sclr = 1'b0;
        set_all(1, 1);
        step(4);
        vld = 1'b0;
        step(12);
        check("sclr_count", longint'(q.size()), 1);
        check_pulse("sclr_frame", 1'b0, 0, c0 + 17, 96, 96, 0);

        // sync_clr on the completing sample suppresses the output
        set_all(7, 0);
        ilen = CW'(1);
        q.delete();
        vld = 1'b1;
        step(1);
        vld = 1'b0;
        step(4);
        sclr = 1'b1;
        step(1);
        sclr = 1'b0;
        step(5);
        check("sclr_done_count", longint'(q.size()), 0);
        check("sclr_done_hold", longint'(sre), 96);

        // int_len = 0 behaves as 1
        set_all(3, -1);
        ilen = '0;
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(2);
        vld = 1'b0;
        step(8);
        check("len0_count", longint'(q.size()), 2);
        check_pulse("len0_p0", 1'b0, 0, c0 + 6, 72, -24, 0);
        check_pulse("len0_p1", 1'b0, 1, c0 + 7, 72, -24, 0);

        // Saturation / wrap at OUT_WIDTH = 40, 256 samples of full-scale real input
        exact = 64'd6144 * 64'h7FFF_FFFF;
`ifdef SATURATE_EN
        sat_exp_re  = (64'sd1 <<< 39) - 1;
        sat_exp_ovf = 1;
`else
        sat_exp_re  = longint'($signed(exact[39:0]));
        sat_exp_ovf = 0;
`endif
        set_all(32'h7FFF_FFFF, 0);
        ilen = CW'(256);
        q.delete();
        c0 = cyc;
        vld = 1'b1;
        step(256);
        vld = 1'b0;
        step(10);
        check("sat_count", longint'(q.size()), 1);
        check_pulse("sat", 1'b0, 0, c0 + 261, sat_exp_re, 0, sat_exp_ovf);

        // Odd channel count: 5 channels, three levels
        for (int k = 0; k < N5; k++) begin
            din5[k*2*IWD +: IWD]     = k + 1;
            din5[k*2*IWD+IWD +: IWD] = -(k + 1);
        end
        ilen5 = CW'(1);
        q5.delete();
        c0 = cyc;
        vld5 = 1'b1;
        step(1);
        vld5 = 1'b0;
        step(8);
        check("odd_count", longint'(q5.size()), 1);
        check_pulse("odd", 1'b1, 0, c0 + 4, 15, -15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beam_sum_tree.md
# beam_sum_tree

Parametrised complex adder tree plus coherent integrator for one beamformer lane. Sums NUM_CH weighted complex channel products from the multiplier array into one beam sample per cycle, then optionally integrates INT_LEN consecutive beam samples before emitting. Supports any channel count, odd levels included, and optional output saturation. Sits between the complex multiplier bank and the beam output formatter.

## Interface
Parameters:
- NUM_CH, `NUM_CH_PER_LANE (24): channels summed; any value ≥ 2.
- IN_WIDTH, `MULT_OUT_WIDTH (32): signed width of each real/imag input.
- OUT_WIDTH, `ACC_WIDTH (48): signed width of each output component.
- CNT_WIDTH, `INT_CNT_WIDTH (10): width of int_len.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in_packed  in  NUM_CH*2*IN_WIDTH  channel k real at [k*2*IN_WIDTH +: IN_WIDTH], imag at the next IN_WIDTH bits.
- in_valid  in  1  data_in_packed valid this cycle.
- int_len  in  CNT_WIDTH  samples per integration; 0 is treated as 1.
- sync_clr  in  1  abort the current integration and flush in-flight valids.
- sum_real, sum_imag  out  OUT_WIDTH  signed integrated result.
- sum_valid  out  1  one-cycle pulse per completed integration.
- sum_ovf  out  1  saturation occurred on this result; qualified by sum_valid.

## Operation
- Tree: LEVELS = clog2(NUM_CH) registered levels. Each level adds pairs; an unpaired odd element is registered through unchanged to keep delay matched.
- Tree width: TW = IN_WIDTH + clog2(NUM_CH), sign-extended at level 1. No overflow is possible inside the tree.
- A valid bit travels with the data through every level.
- Integrator width: IW = TW + CNT_WIDTH. Registers: acc_real, acc_imag, cnt, len_q.
- On the first tree-valid of a frame (cnt == 0): acc ← tree output, len_q ← max(int_len, 1). int_len is sampled only here; changes mid-frame are ignored.
- On subsequent tree-valids: acc ← acc + tree output, cnt increments.
- When the accepted sample is number len_q: the output register loads the final value, sum_valid pulses, and cnt returns to 0.
- Back-to-back frames have no dead cycle.
- A tree-valid gap holds acc and cnt unchanged.
- sync_clr: cnt ← 0, and all tree valid bits are cleared, so in-flight samples are discarded. Tree data registers are not cleared.
- sync_clr together with in_valid: sync_clr wins and the input is dropped.
- sync_clr in the same cycle as a completing sample: the output is suppressed.
- Output conversion from IW to OUT_WIDTH: see Configuration.
- Reset mid-frame: all state is cleared and the partial frame is lost. No output is produced for it.

## Timing
- Reset values: sum_real = 0, sum_imag = 0, sum_valid = 0, sum_ovf = 0. All internal valids, cnt and acc are 0.
- Latency from the in_valid of the last sample of a frame to sum_valid is LEVELS + 1 cycles. For NUM_CH = 24 that is 6 cycles.
- Throughput: one input per cycle. There is no backpressure.
- sum_real, sum_imag and sum_ovf hold their value until the next sum_valid.

## Configuration
- SATURATE_EN defined: the result is clamped to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sum_ovf = 1 if either component was clamped.
- SATURATE_EN undefined: the result is the low OUT_WIDTH bits, two's-complement wrap. sum_ovf is tied to 0.

## Structure
- beamformer_defines.vh gains `INT_CNT_WIDTH and a shared clog2 constant function. It continues to hold `NUM_CH_PER_LANE, `MULT_OUT_WIDTH and `ACC_WIDTH.
- Sub-module cplx_add_level: one registered tree level, N inputs to ceil(N/2) outputs, with valid and odd pass-through. Instantiated LEVELS times in a generate loop.
- The integrator and saturation logic live in beam_sum_tree.

## Test plan
- Reset and mid-frame reset: assert rst for 3 cycles during a frame. All outputs are 0 during reset, and no sum_valid appears for the aborted frame.
- Pass-through mode, NUM_CH = 24, int_len = 1: every channel is real = 1, imag = -2, driven for 10 consecutive cycles. Expect 10 consecutive sum_valid pulses starting at cycle 6, each with sum_real = 24 and sum_imag = -48.
- Integration, int_len = 4: channel k has real = k and imag = 0, for 8 continuous samples. Expect two pulses with sum_real = 1104, 4 cycles apart. Change int_len to 2 mid-frame and confirm it takes effect only in the next frame.
- sync_clr: pulse it after 2 of 4 samples, then send 4 samples of all-ones data. Expect exactly one output, sum_real = 96.
- Saturation, OUT_WIDTH = 40, int_len = 256: all real inputs are 0x7FFFFFFF. With SATURATE_EN, sum_real = 2^39-1 and sum_ovf = 1. Without it, the result equals the low 40 bits of the exact sum and sum_ovf = 0.
- Odd channel count, NUM_CH = 5: inputs have real values 1..5 and imag values -1..-5. Expect sum_real = 15 and sum_imag = -15 with latency 4 cycles.
